// File: rtl/fft_pkg.sv
// Shared FFT definitions: default component width, point count, Q1.14 twiddles
// and helpers that convert between a packed {re,im} word and its components.
package fft_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int N_POINT    = 16;
    localparam int TW_W       = 16;

    // W_k = exp(-j*2*pi*k/16) in Q1.14
    localparam logic signed [TW_W-1:0] W0_RE = 16'sh4000, W0_IM = 16'sh0000;
    localparam logic signed [TW_W-1:0] W1_RE = 16'sh3B21, W1_IM = 16'shE782;
    localparam logic signed [TW_W-1:0] W2_RE = 16'sh2D41, W2_IM = 16'shD2BF;
    localparam logic signed [TW_W-1:0] W3_RE = 16'sh187E, W3_IM = 16'shC4DF;
    localparam logic signed [TW_W-1:0] W4_RE = 16'sh0000, W4_IM = 16'shC000;
    localparam logic signed [TW_W-1:0] W5_RE = 16'shE782, W5_IM = 16'shC4DF;
    localparam logic signed [TW_W-1:0] W6_RE = 16'shD2BF, W6_IM = 16'shD2BF;
    localparam logic signed [TW_W-1:0] W7_RE = 16'shC4DF, W7_IM = 16'shE782;

    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] re;
        logic signed [DEF_DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    function automatic cplx_t unpack_word(input logic [2*DEF_DATA_W-1:0] w);
        cplx_t c;
        c.re = w[2*DEF_DATA_W-1:DEF_DATA_W];
        c.im = w[DEF_DATA_W-1:0];
        return c;
    endfunction

    function automatic logic [2*DEF_DATA_W-1:0] pack_word(input cplx_t c);
        return {c.re, c.im};
    endfunction

endpackage

// File: rtl/fft_bf2_mj.sv
// Combinational radix-2 DIF butterfly; the difference leg is either passed
// through (x1) or rotated by -j, so no multiplier is needed.
module fft_bf2_mj #(
    parameter int DATA_W = 16
) (
    input  logic                rot_mj,
    input  logic [2*DATA_W-1:0] x,
    input  logic [2*DATA_W-1:0] y,
    output logic [2*DATA_W-1:0] top,
    output logic [2*DATA_W-1:0] bot
);

    logic [DATA_W-1:0] xr, xi, yr, yi;
    logic [DATA_W-1:0] sr, si, dr, di, ndr;

    assign xr  = x[2*DATA_W-1:DATA_W];
    assign xi  = x[DATA_W-1:0];
    assign yr  = y[2*DATA_W-1:DATA_W];
    assign yi  = y[DATA_W-1:0];

    assign sr  = xr + yr;
    assign si  = xi + yi;
    assign dr  = xr - yr;
    assign di  = xi - yi;
    assign ndr = yr - xr;

    assign top = {sr, si};
    // (dr + j*di) * (-j) = di - j*dr
    assign bot = rot_mj ? {di, ndr} : {dr, di};

endmodule

// File: rtl/fft_stage3_seq.sv
// Stage 3 of the 16-point radix-2 DIF FFT: capture a frame, run the eight
// span-2 butterflies in place over 8/BF_PER_CYC cycles, then hand it on.
module fft_stage3_seq
    import fft_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BF_PER_CYC = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_POINT*2*DATA_W-1:0]   in_frame,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_POINT*2*DATA_W-1:0]   out_frame,
    output logic                          busy
);

    localparam int WORD_W   = 2 * DATA_W;
    localparam int CALC_CYC = 8 / BF_PER_CYC;
    localparam logic [2:0] CNT_LAST = 3'(CALC_CYC - 1);

    state_t state_q, state_d;
    logic [2:0] cnt_q;
    logic       calc_last;
    logic       out_valid_q;
    logic [N_POINT-1:0][WORD_W-1:0] fbuf_q, fbuf_d;

    logic [BF_PER_CYC-1:0][3:0]        top_idx, bot_idx;
    logic [BF_PER_CYC-1:0]             rot;
    logic [BF_PER_CYC-1:0][WORD_W-1:0] bf_x, bf_y, bf_top, bf_bot;

    assign calc_last = (cnt_q == CNT_LAST);

    // Lane i handles butterfly b = cnt*BF_PER_CYC + i: top = 4g+j, bot = top+2
    for (genvar i = 0; i < BF_PER_CYC; i++) begin : g_bf
        logic [2:0] b;
        assign b          = 3'(32'(cnt_q) * BF_PER_CYC + i);
        assign top_idx[i] = {b[2:1], 1'b0, b[0]};
        assign bot_idx[i] = {b[2:1], 1'b1, b[0]};
        assign rot[i]     = b[0];
        assign bf_x[i]    = fbuf_q[top_idx[i]];
        assign bf_y[i]    = fbuf_q[bot_idx[i]];

        fft_bf2_mj #(.DATA_W(DATA_W)) u_bf (
            .rot_mj (rot[i]),
            .x      (bf_x[i]),
            .y      (bf_y[i]),
            .top    (bf_top[i]),
            .bot    (bf_bot[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_CALC;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (calc_last) state_d = ST_OUT;
            end
            ST_OUT: begin
                busy = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fbuf_d = fbuf_q;
        if (state_q == ST_IDLE && in_valid) begin
            fbuf_d = in_frame;
        end else if (state_q == ST_CALC) begin
            for (int i = 0; i < BF_PER_CYC; i++) begin
                fbuf_d[top_idx[i]] = bf_top[i];
                fbuf_d[bot_idx[i]] = bf_bot[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            fbuf_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fbuf_q <= fbuf_d;
            case (state_q)
                ST_IDLE: if (in_valid) cnt_q <= '0;
                ST_CALC: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (calc_last) out_valid_q <= 1'b1;
                end
                ST_OUT:  if (out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // The bank is frozen outside IDLE/CALC, so it doubles as the output register
    assign out_frame = fbuf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fft_stage3_seq.sv
// Directed and randomized checks of fft_stage3_seq at BF_PER_CYC = 1, 2, 8.
module tb_fft_stage3_seq;

    localparam int FW = 512;
    localparam int NR = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [2:0]    in_valid, out_ready;
    logic [2:0]    in_ready, out_valid, busy;
    logic [FW-1:0] in_frame  [3];
    logic [FW-1:0] out_frame [3];
    logic [FW-1:0] rnd_frames [3][NR];

    int n_cmp  = 0;
    int n_fail = 0;

    fft_stage3_seq #(.DATA_W(16), .BF_PER_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_frame(in_frame[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_frame(out_frame[0]), .busy(busy[0]));
    fft_stage3_seq #(.DATA_W(16), .BF_PER_CYC(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_frame(in_frame[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_frame(out_frame[1]), .busy(busy[1]));
    fft_stage3_seq #(.DATA_W(16), .BF_PER_CYC(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_frame(in_frame[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_frame(out_frame[2]), .busy(busy[2]));

    typedef struct {
        string         name;
        logic [FW-1:0] fin;
        logic [FW-1:0] fexp;
    } vec_t;

    vec_t vecs [4];
    int   lat_exp [3] = '{9, 5, 2};

    function automatic logic [31:0] cw(input logic [15:0] re, input logic [15:0] im);
        return {re, im};
    endfunction

    function automatic logic [FW-1:0] setw(input logic [FW-1:0] f, input int k,
                                           input logic [31:0] w);
        logic [FW-1:0] r;
        r = f;
        r[k*32 +: 32] = w;
        return r;
    endfunction

    // Reference stage 3: span-2 butterflies, -j on the odd one of each group
    function automatic logic [FW-1:0] golden(input logic [FW-1:0] fi);
        logic [FW-1:0] fo;
        logic [15:0]   xr, xi, yr, yi;
        fo = fi;
        for (int g = 0; g < 4; g++) begin
            for (int j = 0; j < 2; j++) begin
                int t, u;
                t  = 4*g + j;
                u  = t + 2;
                xr = fi[t*32+16 +: 16]; xi = fi[t*32 +: 16];
                yr = fi[u*32+16 +: 16]; yi = fi[u*32 +: 16];
                fo[t*32 +: 32] = {16'(xr + yr), 16'(xi + yi)};
                if (j == 0) fo[u*32 +: 32] = {16'(xr - yr), 16'(xi - yi)};
                else        fo[u*32 +: 32] = {16'(xi - yi), 16'(yr - xr)};
            end
        end
        return fo;
    endfunction

    task automatic chk_f(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(negedge clk);
        out_ready[idx] = 1'b1;
        in_valid[idx]  = 1'b1;
        in_frame[idx]  = v.fin;
        chk($sformatf("%s ready[%0d]", v.name, idx), in_ready[idx], 1);
        @(negedge clk);
        in_valid[idx] = 1'b0;
        lat = 1;
        while (!out_valid[idx] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s latency[%0d]", v.name, idx), lat, lat_exp[idx]);
        chk_f($sformatf("%s frame[%0d]", v.name, idx), out_frame[idx], v.fexp);
        @(negedge clk);
        chk($sformatf("%s drop[%0d]", v.name, idx), {out_valid[idx], in_ready[idx]}, 2'b01);
    endtask

    task automatic run_random(input int idx);
        fork
            begin
                for (int f = 0; f < NR; f++) begin
                    int t;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    in_valid[idx] = 1'b1;
                    in_frame[idx] = rnd_frames[idx][f];
                    t = 0;
                    while (!in_ready[idx] && t < 100) begin
                        @(negedge clk);
                        t++;
                    end
                    if (t >= 100) chk($sformatf("rnd accept timeout[%0d]", idx), 0, 1);
                    @(negedge clk);
                    in_valid[idx] = 1'b0;
                end
            end
            begin
                int r, cyc;
                r = 0;
                cyc = 0;
                while (r < NR && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready[idx] = ($urandom_range(0, 3) != 0);
                    if (out_valid[idx] && out_ready[idx]) begin
                        chk_f($sformatf("rnd[%0d] frame %0d", idx, r), out_frame[idx],
                              golden(rnd_frames[idx][r]));
                        r++;
                    end
                end
                chk($sformatf("rnd[%0d] frames out", idx), r, NR);
            end
        join
        out_ready[idx] = 1'b1;
    endtask

    initial begin
        logic [FW-1:0] snap, imp_exp;
        int bad_stable, bad_ready, seen;

        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '1;
        for (int i = 0; i < 3; i++) in_frame[i] = '0;

        vecs[0].name = "impulse";
        vecs[0].fin  = setw('0, 0, cw(16'd100, 16'd0));
        vecs[0].fexp = setw(setw('0, 0, cw(16'd100, 16'd0)), 2, cw(16'd100, 16'd0));
        vecs[1].name = "minus_j";
        vecs[1].fin  = setw('0, 1, cw(16'd3, 16'd5));
        vecs[1].fexp = setw(setw('0, 1, cw(16'd3, 16'd5)), 3, cw(16'd5, 16'hFFFD));
        vecs[2].name = "wrap";
        vecs[2].fin  = setw(setw('0, 0, cw(16'h7FFF, 16'd0)), 2, cw(16'h0001, 16'd0));
        vecs[2].fexp = setw(setw('0, 0, cw(16'h8000, 16'd0)), 2, cw(16'h7FFE, 16'd0));
        vecs[3].name = "mixed";
        vecs[3].fin  = setw(setw(setw(setw(setw(setw('0,
                        0, cw(16'd1, 16'd2)), 1, cw(16'd3, 16'd4)), 2, cw(16'd5, 16'd6)),
                        3, cw(16'd7, 16'd8)), 12, cw(16'd10, 16'd0)), 14, cw(16'd0, 16'd10));
        vecs[3].fexp = setw(setw(setw(setw(setw(setw('0,
                        0, cw(16'd6, 16'd8)), 1, cw(16'd10, 16'd12)), 2, cw(16'hFFFC, 16'hFFFC)),
                        3, cw(16'hFFFC, 16'h0004)), 12, cw(16'd10, 16'd10)), 14, cw(16'd10, 16'hFFF6));

        for (int i = 0; i < 3; i++)
            for (int f = 0; f < NR; f++)
                for (int k = 0; k < 16; k++)
                    rnd_frames[i][f][k*32 +: 32] = $urandom;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset out_valid/busy[%0d]", i), {out_valid[i], busy[i]}, 0);
            chk_f($sformatf("reset out_frame[%0d]", i), out_frame[i], '0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("post-reset in_ready[%0d]", i), in_ready[i], 1);

        // Table vectors on every lane configuration
        for (int i = 0; i < 3; i++)
            for (int v = 0; v < 4; v++) run_vec(i, vecs[v]);

        // Reset mid-CALC discards the frame
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_frame[1] = vecs[0].fin;
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("calc reset out_valid/busy", {out_valid[1], busy[1]}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("calc reset in_ready", in_ready[1], 1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid[1]) seen++;
        end
        chk("calc reset no frame", seen, 0);

        // Reset mid-OUT drops out_valid at once
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        in_frame[1]  = vecs[3].fin;
        @(negedge clk);
        in_valid[1] = 1'b0;
        seen = 0;
        while (!out_valid[1] && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        chk("out reset reached OUT", out_valid[1], 1);
        #2 rst_n = 1'b0;
        #1 chk("out reset out_valid/busy", {out_valid[1], busy[1]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready[1] = 1'b1;
        @(negedge clk);

        // Backpressure: held output, pending input not taken until release
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        in_frame[1]  = vecs[3].fin;
        @(negedge clk);
        in_frame[1] = vecs[0].fin;
        seen = 0;
        while (!out_valid[1] && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        snap = out_frame[1];
        chk_f("bp frame", snap, vecs[3].fexp);
        bad_stable = 0;
        bad_ready  = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_frame[1] !== snap || !out_valid[1]) bad_stable++;
            if (in_ready[1] !== 1'b0) bad_ready++;
        end
        chk("bp stable", bad_stable, 0);
        chk("bp in_ready low", bad_ready, 0);
        out_ready[1] = 1'b1;
        @(negedge clk);
        chk("bp release ready", {out_valid[1], in_ready[1]}, 2'b01);
        @(negedge clk);
        in_valid[1] = 1'b0;
        chk("bp pending taken", {busy[1], in_ready[1]}, 2'b10);
        imp_exp = vecs[0].fexp;
        seen = 0;
        while (!out_valid[1] && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        chk_f("bp second frame", out_frame[1], imp_exp);
        @(negedge clk);

        // Random traffic on all three configurations at once
        fork
            run_random(0);
            run_random(1);
            run_random(2);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
